// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK handling, STOP.
// Latency: 80*DIV cycles accept-to-done (44*DIV on address NACK); start is ignored while busy.
// Backpressure: none on the command side; no SCL clock stretching.
module i2c_byte_master #(
    parameter int DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        SDA,
    output logic       SCL
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_RDATA, S_DACK, S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;

    logic        sda_in;
    logic        tick;
    logic        sample;
    logic        seg_end;
    logic [7:0]  addr_byte;

    assign SDA       = sda_oe_q ? 1'b0 : 1'bz;
    assign sda_in    = SDA;
    assign SCL       = scl_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;

    assign tick      = (div_q == DIV_LAST);
    assign sample    = tick && (qtr_q == 2'd1);
    assign seg_end   = tick && (qtr_q == 2'd3);
    assign addr_byte = {addr_q, rw_q};

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_START;
                addr_d    = dev_addr;
                rw_d      = rw;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
                div_d     = '0;
                qtr_d     = '0;
                bit_d     = '0;
            end
        end else begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        // SDA is sampled mid-way through the SCL high phase
        if (sample) begin
            case (state_q)
                S_AACK:  if (sda_in) ack_err_d = 1'b1;
                S_DACK:  if (!rw_q && sda_in) ack_err_d = 1'b1;
                S_RDATA: begin
                    shift_d = {shift_q[6:0], sda_in};
                    if (bit_q == 3'd7) rdata_d = {shift_q[6:0], sda_in};
                end
                default: ;
            endcase
        end

        if (seg_end) begin
            case (state_q)
                S_START: begin
                    state_d = S_ADDR;
                    bit_d   = '0;
                end
                S_ADDR: begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_AACK;
                end
                S_AACK: begin
                    bit_d = '0;
                    if (ack_err_q)  state_d = S_STOP;
                    else if (rw_q)  state_d = S_RDATA;
                    else            state_d = S_WDATA;
                end
                S_WDATA, S_RDATA: begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_DACK;
                end
                S_DACK: state_d = S_STOP;
                S_STOP: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end

        // Line levels are registered from the upcoming state/quarter
        case (state_d)
            S_IDLE: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
            S_START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = qtr_d[1];
            end
            S_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = !qtr_d[1];
            end
            S_ADDR: begin
                scl_d    = qtr_d[0] ^ qtr_d[1];
                sda_oe_d = !addr_byte[3'd7 - bit_d];
            end
            S_WDATA: begin
                scl_d    = qtr_d[0] ^ qtr_d[1];
                sda_oe_d = !wdata_q[3'd7 - bit_d];
            end
            default: begin
                scl_d    = qtr_d[0] ^ qtr_d[1];
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Bit/byte-level I2C master engine sitting directly downstream of the APB register block (apb_mod).
- Consumes a latched command (start strobe, 7-bit device address, R/W, write byte) and runs one complete single-byte I2C transaction on SDA/SCL.
- Returns read data, busy, done and ack-error status back to the register block.

Parameters:
- DIV, 125, clk cycles per SCL quarter-period (SCL period = 4*DIV clk cycles); legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command strobe; accepted only when busy=0
- rw  input  1  1 = read, 0 = write
- dev_addr  input  7  target device address
- wdata  input  8  byte to transmit in a write
- rdata  output  8  byte received in a read
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse at end of transaction
- ack_err  output  1  slave NACKed address or write data
- SDA  inout  1  open-drain: driven 0 or high-Z, never driven 1
- SCL  output  1  push-pull clock; no clock stretching supported

Behaviour:
- Reset (async, reset=0): state IDLE, SCL=1, SDA=Z, busy=0, done=0, ack_err=0, rdata=0, divider and bit counters cleared. Reset asserted mid-transaction aborts immediately with these values; no STOP is generated.
- Accept: in IDLE with start=1 at a rising edge, latch dev_addr, rw and wdata; clear ack_err; busy=1 from the next cycle; divider restarts at 0. start is ignored while busy=1.
- Quarter tick: divider counts 0..DIV-1; the tick fires when the count reaches DIV-1. Each segment below lasts 4 quarters (q0..q3).
- States: IDLE -> START -> ADDR (8 bits: dev_addr MSB first, then rw) -> AACK -> WDATA or RDATA (8 bits) -> DACK -> STOP -> IDLE.
- START: q0,q1 SCL=1, SDA=Z; q2 SDA=0; q3 SCL=0, SDA=0.
- Bit segment (ADDR/WDATA/AACK/RDATA/DACK): q0 SCL=0, SDA set to the bit being sent (0 -> drive 0, 1 -> Z); q1,q2 SCL=1; q3 SCL=0. SDA is sampled at the q1->q2 boundary. SDA is held stable throughout q1..q3.
- AACK: SDA released. Sampled 1 -> ack_err=1, skip data, go to STOP. Sampled 0 -> go to WDATA (rw=0) or RDATA (rw=1).
- WDATA: wdata MSB first. DACK: SDA released; sampled 1 -> ack_err=1. STOP follows either way.
- RDATA: SDA released; sampled bits shift into rdata MSB first. rdata updates only at the final (8th) sample and then holds. DACK (read): master sends NACK (SDA=Z).
- STOP: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2,q3 SCL=1, SDA=Z. At the end of q3: done=1 for one cycle, busy=0, state IDLE.
- Total quarters from accept to done:
  - full transaction: 4*(1+9+9+1) = 80
  - address NACK: 4*(1+9+1) = 44
- done asserts exactly quarters*DIV cycles after the accept edge. A new start is accepted in the same cycle done=1, since busy=0 is visible then.
- ack_err and rdata hold their values until the next accept (ack_err) or the next completed read (rdata).

Test Plan:
- Reset check: reset=0 -> SCL=1, SDA=Z, busy=0, done=0, ack_err=0, rdata=0 during reset and on the first cycle after release.
- Write, DIV=2, dev_addr=0x50, rw=0, wdata=0xA5, slave model ACKs both -> bits captured 0xA0 then 0xA5; 18 SCL pulses before STOP; done 160 cycles after accept; ack_err=0.
- Read, DIV=2, dev_addr=0x3C, rw=1, slave returns 0x5A -> rdata=0x5A at done; master SDA=Z on the 9th data bit (NACK); done at 160 cycles.
- Address NACK, DIV=2, slave never ACKs -> ack_err=1; 9 SCL pulses; STOP generated; done 88 cycles after accept.
- Write data NACK -> ack_err=1, full 160-cycle transaction; start pulses while busy=1 are ignored (no restart, latched wdata unchanged).
- Reset asserted at cycle 70 of a write -> immediate SCL=1, SDA=Z, busy=0; a start after release runs a clean 160-cycle transaction.
